// File: rtl/freg_file_mp.sv
// freg_file_mp: floating-point register file with two registered read ports,
// one write port and a per-entry busy scoreboard, zeroed by a clear sequence
// after every reset.
//
// Ports:
//   clock, reset            - single clock, synchronous active-high reset
//   ready                   - high once the clear sequence has finished
//   regWrite/regDest/writeData - write port (also releases the busy bit)
//   readReg1/readReg2       - read addresses
//   readData1/readData2     - registered read data (one-cycle latency)
//   markBusy/markReg        - sets the busy bit of an entry
//   busy1/busy2             - combinational busy flags for readReg1/readReg2
//
// Optional feature macro: FREG_BYPASS_EN forwards a same-edge write to a
// matching read port; without it the read returns the pre-write value.
module freg_file_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic             clock,
    input  logic             reset,
    output logic             ready,
    input  logic             regWrite,
    input  logic [AW-1:0]    regDest,
    input  logic [WIDTH-1:0] writeData,
    input  logic [AW-1:0]    readReg1,
    input  logic [AW-1:0]    readReg2,
    output logic [WIDTH-1:0] readData1,
    output logic [WIDTH-1:0] readData2,
    input  logic             markBusy,
    input  logic [AW-1:0]    markReg,
    output logic             busy1,
    output logic             busy2
);
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [0:0]       state;
    logic [AW-1:0]    clrIdx;
    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busyBits;
    logic [DEPTH-1:0] nextBusy;
    logic             wrEn;
    logic             mkEn;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;

    assign ready = state == READY;
    assign busy1 = busyBits[readReg1];
    assign busy2 = busyBits[readReg2];

    always_comb begin
        wrEn = ready && regWrite && !(ZERO_REG != 0 && regDest == '0);
        mkEn = ready && markBusy && !(ZERO_REG != 0 && markReg == '0);
        rd1 = (ZERO_REG != 0 && readReg1 == '0) ? '0 : regs[readReg1];
        rd2 = (ZERO_REG != 0 && readReg2 == '0) ? '0 : regs[readReg2];
`ifdef FREG_BYPASS_EN
        rd1 = (wrEn && regDest == readReg1) ? writeData : rd1;
        rd2 = (wrEn && regDest == readReg2) ? writeData : rd2;
`endif
        // Mark is applied after the write release so a same-cycle mark wins.
        nextBusy = busyBits;
        if (wrEn) nextBusy[regDest] = 1'b0;
        if (mkEn) nextBusy[markReg] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= CLEAR;
            clrIdx    <= '0;
            busyBits  <= '0;
            readData1 <= '0;
            readData2 <= '0;
        end else if (state == CLEAR) begin
            clrIdx    <= clrIdx + AW'(1);
            state     <= (clrIdx == AW'(DEPTH - 1)) ? READY : CLEAR;
            readData1 <= '0;
            readData2 <= '0;
        end else begin
            readData1 <= rd1;
            readData2 <= rd2;
            busyBits  <= nextBusy;
        end
    end

    // Storage has no reset of its own; the clear sequence zeroes it one entry per cycle.
    always_ff @(posedge clock) begin
        if (!reset && (state == CLEAR || wrEn))
            regs[(state == CLEAR) ? clrIdx : regDest] <= (state == CLEAR) ? '0 : writeData;
    end
endmodule

// File: tb/tb_freg_file_mp.sv
// tb_freg_file_mp: randomized and directed scoreboard bench for freg_file_mp.
module tb_freg_file_mp;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int ZR    = 1;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             ready;
    logic             regWrite = 1'b0;
    logic [AW-1:0]    regDest = '0;
    logic [WIDTH-1:0] writeData = '0;
    logic [AW-1:0]    readReg1 = '0;
    logic [AW-1:0]    readReg2 = '0;
    logic [WIDTH-1:0] readData1;
    logic [WIDTH-1:0] readData2;
    logic             markBusy = 1'b0;
    logic [AW-1:0]    markReg = '0;
    logic             busy1;
    logic             busy2;

    freg_file_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZR)) dut (
        .clock(clock), .reset(reset), .ready(ready),
        .regWrite(regWrite), .regDest(regDest), .writeData(writeData),
        .readReg1(readReg1), .readReg2(readReg2),
        .readData1(readData1), .readData2(readData2),
        .markBusy(markBusy), .markReg(markReg),
        .busy1(busy1), .busy2(busy2)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic             rdy;
        logic [WIDTH-1:0] rd1;
        logic [WIDTH-1:0] rd2;
        logic             b1;
        logic             b2;
    } expect_t;

    expect_t          q[$];
    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] mMem [DEPTH];
    bit               mBusy [DEPTH];
    int               sinceReset = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] mRead(input logic [AW-1:0] a);
        return (ZR != 0 && a == 0) ? '0 : mMem[a];
    endfunction

    // Drive one cycle of stimulus, then update the reference model for that edge.
    task automatic step(input bit rst, input bit wr, input logic [AW-1:0] dest,
                        input logic [WIDTH-1:0] data, input logic [AW-1:0] r1,
                        input logic [AW-1:0] r2, input bit mk, input logic [AW-1:0] mreg);
        expect_t e;
        bit      wrOk;
        bit      mkOk;
        @(negedge clock);
        reset = rst; regWrite = wr; regDest = dest; writeData = data;
        readReg1 = r1; readReg2 = r2; markBusy = mk; markReg = mreg;
        @(posedge clock);
        #1;
        wrOk = wr && !(ZR != 0 && dest == 0);
        mkOk = mk && !(ZR != 0 && mreg == 0);
        e.rd1 = '0;
        e.rd2 = '0;
        if (rst) begin
            sinceReset = 0;
            for (int i = 0; i < DEPTH; i++) begin mMem[i] = '0; mBusy[i] = 0; end
        end else if (sinceReset < DEPTH) begin
            sinceReset++;
        end else begin
            e.rd1 = mRead(r1);
            e.rd2 = mRead(r2);
`ifdef FREG_BYPASS_EN
            if (wrOk && dest == r1) e.rd1 = data;
            if (wrOk && dest == r2) e.rd2 = data;
`endif
            if (wrOk) begin mMem[dest] = data; mBusy[dest] = 0; end
            if (mkOk) mBusy[mreg] = 1;
        end
        e.rdy = sinceReset >= DEPTH;
        e.b1  = mBusy[r1];
        e.b2  = mBusy[r2];
        q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [AW-1:0] r1);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, r1, r1, 0, 0);
    endtask

    initial begin : monitor
        expect_t e;
        forever begin
            @(posedge clock);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                chk("ready", {31'b0, ready}, {31'b0, e.rdy});
                chk("readData1", readData1, e.rd1);
                chk("readData2", readData2, e.rd2);
                chk("busy1", {31'b0, busy1}, {31'b0, e.b1});
                chk("busy2", {31'b0, busy2}, {31'b0, e.b2});
            end
        end
    end

    initial begin : stimulus
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(DEPTH, 7);
        // Reset clear: write entry 7, then reset and confirm it reads back as zero.
        step(0, 1, 7, 32'hDEADBEEF, 7, 7, 0, 0);
        idle(1, 7);
        step(1, 0, 0, 0, 7, 7, 0, 0);
        idle(DEPTH, 7);
        idle(2, 7);
        // Basic write/read on both ports.
        step(0, 1, 5, 32'h3F800000, 0, 0, 0, 0);
        step(0, 0, 0, 0, 5, 5, 0, 0);
        idle(1, 5);
        // Zero register: write and mark entry 0.
        step(0, 1, 0, 32'h40490FDB, 0, 0, 1, 0);
        idle(2, 0);
        // Collision on entry 9.
        step(0, 1, 9, 32'h11111111, 0, 0, 0, 0);
        step(0, 1, 9, 32'h22222222, 9, 9, 0, 0);
        idle(2, 9);
        // Scoreboard: mark, mark+write, lone write on entry 12.
        step(0, 0, 0, 0, 12, 12, 1, 12);
        step(0, 1, 12, 32'h12121212, 12, 12, 1, 12);
        step(0, 1, 12, 32'h34343434, 12, 12, 0, 0);
        idle(1, 12);
        // Reset mid-clear.
        step(1, 0, 0, 0, 3, 3, 0, 0);
        idle(10, 3);
        step(1, 0, 0, 0, 3, 3, 0, 0);
        idle(DEPTH, 3);
        // Randomized traffic with addresses biased toward collisions.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 1),
                 AW'($urandom_range(0, 7)), $urandom,
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, DEPTH - 1)),
                 $urandom_range(0, 3) == 0, AW'($urandom_range(0, 7)));
        end
        @(posedge clock);
        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
